// File: rtl/program_counter_if.sv
// Control and data bundle between the sequencer/ALU path and the program counter.
interface program_counter_if #(
  parameter int unsigned WIDTH = 16
);
  logic [WIDTH-1:0] IN;
  logic             LOAD;
  logic             INC;
  logic             CLR;
  logic [WIDTH-1:0] OUT;
  logic             WRAP;

  modport master (
    output IN, LOAD, INC, CLR,
    input  OUT, WRAP
  );

  modport slave (
    input  IN, LOAD, INC, CLR,
    output OUT, WRAP
  );
endinterface

// File: rtl/program_counter.sv
// Registered program counter: per-bit mux chain (clear > load > increment > hold)
// fed by a ripple half-adder incrementer, plus a one-cycle wrap-around pulse.
module program_counter #(
  parameter int unsigned WIDTH       = 16,
  parameter logic [31:0] RESET_VALUE = '0
) (
  input logic          CLK,
  input logic          RST,
  program_counter_if.slave pc
);

  localparam logic [WIDTH-1:0] RST_VAL = RESET_VALUE[WIDTH-1:0];

  logic [WIDTH-1:0] count_q;
  logic             wrap_q;
  logic [WIDTH-1:0] count_d;
  logic             wrap_d;
  logic             carry;
  logic             sum_bit;
  logic             bit_d;

  // Carry ripples LSB to MSB with carry-in of 1; the final carry is the
  // all-ones condition and never feeds back into the count.
  always_comb begin
    carry   = 1'b1;
    sum_bit = 1'b0;
    bit_d   = 1'b0;
    count_d = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      sum_bit    = count_q[i] ^ carry;
      carry      = count_q[i] & carry;
      bit_d      = pc.INC  ? sum_bit    : count_q[i];
      bit_d      = pc.LOAD ? pc.IN[i]   : bit_d;
      bit_d      = pc.CLR  ? RST_VAL[i] : bit_d;
      count_d[i] = bit_d;
    end
    wrap_d = carry & pc.INC & ~pc.LOAD & ~pc.CLR;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      count_q <= RST_VAL;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign pc.OUT  = count_q;
  assign pc.WRAP = wrap_q;

endmodule

// File: tb/tb_program_counter.sv
// Randomized self-checking bench for program_counter: a 16-bit instance and an
// 8-bit instance with a truncated reset value, both against arithmetic models.
module tb_program_counter;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  program_counter_if #(.WIDTH(16)) pc16 ();
  program_counter_if #(.WIDTH(8))  pc8  ();

  program_counter #(.WIDTH(16), .RESET_VALUE(32'h0000_0000)) dut16 (
    .CLK (CLK),
    .RST (RST),
    .pc  (pc16.slave)
  );

  program_counter #(.WIDTH(8), .RESET_VALUE(32'h0000_0100)) dut8 (
    .CLK (CLK),
    .RST (RST),
    .pc  (pc8.slave)
  );

  always #5 CLK = ~CLK;

  logic [15:0] in16 = '0;
  logic        clr16 = 1'b0, load16 = 1'b0, inc16 = 1'b0;
  logic [7:0]  in8 = '0;
  logic        clr8 = 1'b0, load8 = 1'b0, inc8 = 1'b0;

  assign pc16.IN   = in16;
  assign pc16.CLR  = clr16;
  assign pc16.LOAD = load16;
  assign pc16.INC  = inc16;
  assign pc8.IN    = in8;
  assign pc8.CLR   = clr8;
  assign pc8.LOAD  = load8;
  assign pc8.INC   = inc8;

  // Reference state: plain integers, modulo arithmetic.
  int unsigned m16 = 0, m8 = 0;
  bit          w16 = 1'b0, w8 = 1'b0;
  int unsigned rv16 = 32'h0000 % 65536;
  int unsigned rv8  = 32'h0100 % 256;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic model_reset();
    m16 = rv16; w16 = 1'b0;
    m8  = rv8;  w8  = 1'b0;
  endtask

  task automatic model_edge();
    if (clr16)       begin m16 = rv16; w16 = 1'b0; end
    else if (load16) begin m16 = in16; w16 = 1'b0; end
    else if (inc16)  begin w16 = (m16 == 65535); m16 = (m16 + 1) % 65536; end
    else             w16 = 1'b0;
    if (clr8)        begin m8 = rv8; w8 = 1'b0; end
    else if (load8)  begin m8 = in8; w8 = 1'b0; end
    else if (inc8)   begin w8 = (m8 == 255); m8 = (m8 + 1) % 256; end
    else             w8 = 1'b0;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".out16"},  32'(pc16.OUT),  m16);
    check({tag, ".wrap16"}, 32'(pc16.WRAP), 32'(w16));
    check({tag, ".out8"},   32'(pc8.OUT),   m8);
    check({tag, ".wrap8"},  32'(pc8.WRAP),  32'(w8));
  endtask

  task automatic step(input string tag);
    @(posedge CLK);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic set16(input logic c, input logic l, input logic i, input logic [15:0] v);
    clr16 = c; load16 = l; inc16 = i; in16 = v;
  endtask

  task automatic set8(input logic c, input logic l, input logic i, input logic [7:0] v);
    clr8 = c; load8 = l; inc8 = i; in8 = v;
  endtask

  // Called #1 after an edge: asserts RST mid-cycle and checks before the next edge.
  task automatic mid_cycle_reset(input string tag);
    #4;
    RST = 1'b1;
    model_reset();
    #1;
    check_all(tag);
    #1;
    RST = 1'b0;
  endtask

  initial begin
    // Reset held across running clock edges with a pending load.
    set16(1'b0, 1'b1, 1'b0, 16'h1234);
    set8(1'b0, 1'b1, 1'b0, 8'h5A);
    model_reset();
    repeat (3) @(posedge CLK);
    #1;
    check_all("reset");
    check("reset.abs16", 32'(pc16.OUT), 32'h0);
    check("reset.abs8",  32'(pc8.OUT),  32'h0);

    RST = 1'b0;
    set16(1'b0, 1'b0, 1'b1, 16'h0);
    set8(1'b0, 1'b0, 1'b0, 8'h0);
    step("first_inc");
    check("first_inc.abs", 32'(pc16.OUT), 32'h1);

    repeat (4) step("inc");
    check("inc5.abs", 32'(pc16.OUT), 32'h5);
    set16(1'b0, 1'b0, 1'b0, 16'h0);
    repeat (3) step("hold");
    check("hold.abs", 32'(pc16.OUT), 32'h5);

    set16(1'b0, 1'b1, 1'b1, 16'h00A0);
    step("load_over_inc");
    check("load_over_inc.abs", 32'(pc16.OUT), 32'h00A0);
    set16(1'b1, 1'b1, 1'b1, 16'h0F0F);
    step("clr_over_load");
    check("clr_over_load.abs", 32'(pc16.OUT), 32'h0);

    set16(1'b0, 1'b1, 1'b0, 16'hFFFE);
    step("load_fffe");
    set16(1'b0, 1'b0, 1'b1, 16'h0);
    step("to_ffff");
    check("to_ffff.wrap", 32'(pc16.WRAP), 32'h0);
    step("to_0000");
    check("to_0000.wrap", 32'(pc16.WRAP), 32'h1);
    step("to_0001");
    check("to_0001.wrap", 32'(pc16.WRAP), 32'h0);

    set16(1'b0, 1'b1, 1'b0, 16'h0042);
    step("load_42");
    set16(1'b0, 1'b0, 1'b1, 16'h0);
    step("count_43");
    mid_cycle_reset("async_rst");
    check("async_rst.abs", 32'(pc16.OUT), 32'h0);

    // 8-bit instance: truncated reset value, CLR, and wrap from all-ones.
    set16(1'b0, 1'b0, 1'b0, 16'h0);
    set8(1'b0, 1'b1, 1'b0, 8'h77);
    step("w8_load");
    set8(1'b1, 1'b0, 1'b1, 8'h0);
    step("w8_clr");
    check("w8_clr.abs", 32'(pc8.OUT), 32'h0);
    set8(1'b0, 1'b1, 1'b0, 8'hFF);
    step("w8_load_ff");
    set8(1'b0, 1'b0, 1'b1, 8'h0);
    step("w8_wrap");
    check("w8_wrap.abs", {23'h0, pc8.WRAP, pc8.OUT}, 32'h100);
    step("w8_after_wrap");

    // Randomized phase, biased toward loads near all-ones to exercise wraps.
    for (int k = 0; k < 600; k++) begin
      logic [15:0] v16;
      logic [7:0]  v8;
      v16 = ($urandom_range(0, 3) == 0) ? 16'hFFFF - 16'($urandom_range(0, 2)) : 16'($urandom);
      v8  = ($urandom_range(0, 3) == 0) ? 8'hFF - 8'($urandom_range(0, 2)) : 8'($urandom);
      set16($urandom_range(0, 15) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 3) != 0, v16);
      set8($urandom_range(0, 15) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 3) != 0, v8);
      step("rand");
      if ($urandom_range(0, 49) == 0)
        mid_cycle_reset("rand_rst");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, limit %0t", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/program_counter.md
Name: program_counter

Overview:
- Registered WIDTH-bit counter whose next value comes from a per-bit priority chain of 2:1 Multiplexer stages: clear, then load, then increment, then hold.
- Sits directly upstream of the Multiplexer-based datapath. OUT drives instruction-address and select logic. IN is fed back from the ALU/jump-target path.
- Also flags counter wrap-around for the sequencer.

Parameters:
WIDTH, 16, counter and data width in bits (legal range 2..32)
RESET_VALUE, 0, value OUT takes on asynchronous reset and on synchronous CLR

Ports:
CLK  input  1  clock, all state updates on rising edge
RST  input  1  asynchronous active-high reset
IN  input  WIDTH  load value
LOAD  input  1  load IN on next edge
INC  input  1  increment on next edge
CLR  input  1  synchronous clear to RESET_VALUE
OUT  output  WIDTH  current counter value (registered)
WRAP  output  1  registered one-cycle pulse: last update was an increment from all-ones to zero

Behaviour:
- Reset: RST is asynchronous and active-high. While RST=1: OUT=RESET_VALUE, WRAP=0, independent of CLK. First edge after RST deasserts applies normal rules.
- Next-state priority, evaluated each rising CLK edge:
  - CLR=1: OUT<=RESET_VALUE, WRAP<=0.
  - else LOAD=1: OUT<=IN, WRAP<=0.
  - else INC=1: OUT<=OUT+1 modulo 2^WIDTH. WRAP<=1 iff OUT was all-ones, else 0.
  - else hold: OUT unchanged, WRAP<=0.
- Simultaneous controls: priority above is absolute. LOAD+INC loads IN, no increment. CLR+anything clears.
- Latency: one cycle from control sampled to OUT visible. No combinational path from any input to OUT or WRAP.
- Arithmetic:
  - Incrementer is a WIDTH-bit ripple half-adder chain. Carry-in=1 for the increment term; carry-out of the MSB is the wrap condition.
  - Carry-out is never added into OUT.
- Structure:
  - Per bit: mux(hold, inc) on INC, then mux(·, IN) on LOAD, then mux(·, RESET_VALUE bit) on CLR, then the flop.
  - WRAP is its own flop fed by carry-out AND INC AND NOT LOAD AND NOT CLR.
- WRAP is high for exactly one cycle per wrap. Consecutive wraps are impossible unless WIDTH-bit re-load to all-ones precedes each increment.
- Reset mid-operation: asserting RST between edges forces outputs immediately. Pending controls are discarded.
- X on control inputs is not required to be handled. Bench drives known values after reset.

Test Plan:
- Reset: RST=1 with LOAD=1, IN=16'h1234, clocks running → OUT=16'h0000, WRAP=0. Release RST with INC=1 → OUT=1 after first edge.
- Increment/hold: from 0, INC=1 for 5 edges → OUT=5. INC=0 for 3 edges → OUT stays 5, WRAP stays 0.
- Load priority: OUT=5, LOAD=1, INC=1, IN=16'h00A0 → OUT=16'h00A0 next edge. Then CLR=1, LOAD=1 → OUT=0.
- Wrap: LOAD IN=16'hFFFE, then INC ×3 → OUT=FFFF, 0000, 0001. WRAP=1 only in the cycle OUT=0000.
- Async reset mid-count: OUT=16'h0042 counting. Assert RST half a cycle after an edge → OUT=0 before the next edge. WRAP=0.
- RESET_VALUE=16'h0100, WIDTH=8 instance (value truncated to 8'h00): confirm reset/CLR → 8'h00. INC from 8'hFF → 8'h00 with WRAP=1.
